// File: rtl/uno_seq_if.sv
// Request, coefficient-config, PE-control and response signals of the PE sequencer.
// master = request/PE side (drives requests, pe_result, rsp_ready); slave = uno_seq.
interface uno_seq_if #(
  parameter int MAC_BW = 12,
  parameter int LEN_BW = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [LEN_BW-1:0]     req_len;
  logic                  cfg_we;
  logic [1:0]            cfg_op;
  logic [2:0]            cfg_idx;
  logic [MAC_BW-1:0]     cfg_data;
  logic                  cfg_ready;
  logic [1:0]            pe_op;
  logic [MAC_BW-1:0]     pe_coeff;
  logic                  pe_first;
  logic                  pe_last;
  logic                  pe_acc_en;
  logic                  opnd_pop;
  logic [2*MAC_BW-1:0]   pe_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*MAC_BW-1:0]   rsp_data;

  modport master (
    output req_valid, req_op, req_len, cfg_we, cfg_op, cfg_idx, cfg_data,
           pe_result, rsp_ready,
    input  req_ready, cfg_ready, pe_op, pe_coeff, pe_first, pe_last,
           pe_acc_en, opnd_pop, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_len, cfg_we, cfg_op, cfg_idx, cfg_data,
           pe_result, rsp_ready,
    output req_ready, cfg_ready, pe_op, pe_coeff, pe_first, pe_last,
           pe_acc_en, opnd_pop, rsp_valid, rsp_data
  );
endinterface

// File: rtl/uno_seq.sv
// Issue sequencer for the unified PE: drives MAC beats or Horner coefficient steps, captures the result.
// Latency 1+N+MAC_LAT (MAC) or 2+TERMS+MAC_LAT (nonlinear); one op in flight, rsp held until rsp_ready.
module uno_seq #(
  parameter int MAC_BW  = 12,
  parameter int TERMS   = 4,
  parameter int LEN_BW  = 8,
  parameter int MAC_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uno_seq_if.slave bus
);

  localparam int                IW      = $clog2(TERMS);
  localparam logic [3:0]        TERMS_W = 4'(TERMS);
  localparam logic [LEN_BW-1:0] LAST_K  = LEN_BW'(TERMS - 1);
  localparam logic [LEN_BW-1:0] LAST_D  = LEN_BW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    FIN,
    DRAIN,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_BW-1:0] cnt, cnt_nxt;
  logic [LEN_BW-1:0] last_beat;
  logic [1:0]        op_q;
  logic [MAC_BW-1:0] tbl [1:3][TERMS];
  logic              req_fire;
  logic              cfg_hit;
  logic              drain_done;

  assign req_fire   = (state == IDLE) && bus.req_valid;
  assign cfg_hit    = (state == IDLE) && bus.cfg_we && (bus.cfg_op != 2'b00) &&
                      ({1'b0, bus.cfg_idx} < TERMS_W);
  assign drain_done = (state == DRAIN) && (cnt == LAST_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 2'b00;
      last_beat    <= '0;
      bus.rsp_data <= '0;
    end else begin
      if (req_fire) begin
        op_q      <= bus.req_op;
        // A zero-length MAC still runs one beat.
        last_beat <= (bus.req_len == '0) ? '0 : bus.req_len - 1'b1;
      end
      if (drain_done) begin
        bus.rsp_data <= bus.pe_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r <= 3; r++) begin
        for (int i = 0; i < TERMS; i++) begin
          tbl[r][i] <= '0;
        end
      end
    end else if (cfg_hit) begin
      tbl[bus.cfg_op][bus.cfg_idx[IW-1:0]] <= bus.cfg_data;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.req_ready = 1'b0;
    bus.cfg_ready = 1'b0;
    bus.pe_op     = (state == IDLE) ? 2'b00 : op_q;
    bus.pe_coeff  = '0;
    bus.pe_first  = 1'b0;
    bus.pe_last   = 1'b0;
    bus.pe_acc_en = 1'b0;
    bus.opnd_pop  = 1'b0;
    bus.rsp_valid = 1'b0;

    case (state)
      IDLE: begin
        // Readies are forced low while reset is held, not just after it.
        bus.req_ready = rst_n;
        bus.cfg_ready = rst_n;
        if (bus.req_valid) begin
          state_nxt = ISSUE;
          cnt_nxt   = '0;
        end
      end

      ISSUE: begin
        if (op_q == 2'b00) begin
          bus.opnd_pop  = 1'b1;
          bus.pe_acc_en = (cnt != '0);
          if (cnt == last_beat) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          bus.pe_coeff = tbl[op_q][cnt[IW-1:0]];
          bus.pe_first = (cnt == '0);
          bus.opnd_pop = (cnt == '0);
          if (cnt == LAST_K) begin
            state_nxt = FIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      FIN: begin
        bus.pe_last = 1'b1;
        state_nxt   = DRAIN;
        cnt_nxt     = '0;
      end

      DRAIN: begin
        if (cnt == LAST_D) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  a_first_last_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.pe_first && bus.pe_last));

  a_acc_mac_only: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.pe_op != 2'b00) |-> !bus.pe_acc_en);

endmodule

// File: tb/tb_uno_seq.sv
// Randomized scoreboard bench for uno_seq: the driver pushes per-cycle PE-control and response
// expectations derived from the op rules; a negedge monitor pops and compares.
module tb_uno_seq;

  localparam int MAC_BW  = 12;
  localparam int TERMS   = 4;
  localparam int LEN_BW  = 8;
  localparam int MAC_LAT = 1;

  typedef struct packed {
    logic [1:0]        op;
    logic [MAC_BW-1:0] coeff;
    logic              first;
    logic              last;
    logic              acc;
    logic              pop;
  } ctl_t;

  typedef struct {
    int   cyc;
    ctl_t c;
  } ctl_exp_t;

  typedef struct {
    int         hs;
    int         vcyc;
    int         cap;
    logic [1:0] op;
  } rsp_exp_t;

  logic clk;
  logic rst_n;

  uno_seq_if #(.MAC_BW(MAC_BW), .LEN_BW(LEN_BW)) bus ();

  uno_seq #(
    .MAC_BW (MAC_BW),
    .TERMS  (TERMS),
    .LEN_BW (LEN_BW),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  ctl_exp_t          cq[$];
  rsp_exp_t          rq[$];
  logic [MAC_BW-1:0] mdl [1:3][0:TERMS-1];
  logic [23:0]       hist [0:8191];
  int                cyc      = 0;
  int                checks   = 0;
  int                failures = 0;
  bit                hold_low = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // PE result and response-side backpressure change every cycle.
  always @(posedge clk) begin
    #1;
    bus.pe_result = 24'($urandom);
    hist[cyc % 8192] = bus.pe_result;
    bus.rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 1) == 1);
  end

  always @(negedge clk) begin
    ctl_t     act;
    ctl_t     exp;
    ctl_exp_t e;
    bit       busy;
    bit       ev;
    act = '{bus.pe_op, bus.pe_coeff, bus.pe_first, bus.pe_last, bus.pe_acc_en, bus.opnd_pop};
    if (!rst_n) begin
      check("rst_ctl", 32'(act), 32'd0);
      check("rst_flags", {29'd0, bus.req_ready, bus.cfg_ready, bus.rsp_valid}, 32'd0);
      check("rst_data", 32'(bus.rsp_data), 32'd0);
    end else begin
      busy = (rq.size() > 0) && (cyc > rq[0].hs);
      exp  = '0;
      if (busy) exp.op = rq[0].op;
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        e   = cq.pop_front();
        exp = e.c;
      end
      check("pe_ctl", 32'(act), 32'(exp));
      check("req_ready", 32'(bus.req_ready), 32'(!busy));
      check("cfg_ready", 32'(bus.cfg_ready), 32'(!busy));
      ev = busy && (cyc >= rq[0].vcyc);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
      if (ev) begin
        check("rsp_data", 32'(bus.rsp_data), 32'(hist[rq[0].cap % 8192]));
        if (bus.rsp_ready) void'(rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_cfg(logic [1:0] op, logic [2:0] idx, logic [MAC_BW-1:0] d);
    if (rq.size() == 0 && op != 2'b00 && int'(idx) < TERMS) mdl[op][int'(idx)] = d;
  endfunction

  function automatic void push_expect(logic [1:0] op, int len);
    ctl_exp_t e;
    rsp_exp_t r;
    int       n;
    r.hs = cyc;
    r.op = op;
    if (op == 2'b00) begin
      n = (len == 0) ? 1 : len;
      for (int b = 0; b < n; b++) begin
        e.cyc = cyc + 1 + b;
        e.c   = '{2'b00, '0, 1'b0, 1'b0, (b != 0), 1'b1};
        cq.push_back(e);
      end
      r.vcyc = cyc + 1 + n + MAC_LAT;
    end else begin
      for (int j = 0; j < TERMS; j++) begin
        e.cyc = cyc + 1 + j;
        e.c   = '{op, mdl[op][j], (j == 0), 1'b0, 1'b0, (j == 0)};
        cq.push_back(e);
      end
      e.cyc = cyc + 1 + TERMS;
      e.c   = '{op, '0, 1'b0, 1'b1, 1'b0, 1'b0};
      cq.push_back(e);
      r.vcyc = cyc + 1 + TERMS + 1 + MAC_LAT;
    end
    r.cap = r.vcyc - 1;
    rq.push_back(r);
  endfunction

  task automatic drive(bit we, logic [1:0] cop, logic [2:0] idx, logic [MAC_BW-1:0] d,
                       bit rv, logic [1:0] rop, logic [LEN_BW-1:0] rlen);
    bus.cfg_we    = we;
    bus.cfg_op    = cop;
    bus.cfg_idx   = idx;
    bus.cfg_data  = d;
    bus.req_valid = rv;
    bus.req_op    = rop;
    bus.req_len   = rlen;
    if (we) model_cfg(cop, idx, d);
    if (rv) push_expect(rop, int'(rlen));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (rq.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    check("idle_timeout", 32'(rq.size()), 32'd0);
  endtask

  task automatic issue(logic [1:0] op, logic [LEN_BW-1:0] len);
    wait_idle();
    drive(1'b0, 2'b00, 3'd0, '0, 1'b1, op, len);
    tick();
    drive(1'b0, 2'b00, 3'd0, '0, 1'b0, 2'b00, '0);
  endtask

  task automatic cfg_write(logic [1:0] op, logic [2:0] idx, logic [MAC_BW-1:0] d);
    drive(1'b1, op, idx, d, 1'b0, 2'b00, '0);
    tick();
    drive(1'b0, 2'b00, 3'd0, '0, 1'b0, 2'b00, '0);
  endtask

  task automatic clear_model();
    for (int r = 1; r <= 3; r++)
      for (int i = 0; i < TERMS; i++) mdl[r][i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.pe_result = '0;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 2'b00, 3'd0, '0, 1'b0, 2'b00, '0);
    clear_model();

    // Reset held with random inputs: everything must stay at zero.
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.cfg_we    = 1'($urandom);
      bus.cfg_op    = 2'($urandom);
      bus.cfg_idx   = 3'($urandom);
      bus.cfg_data  = 12'($urandom);
      bus.req_valid = 1'($urandom);
      bus.req_op    = 2'($urandom);
      bus.req_len   = 8'($urandom);
    end
    tick();
    drive(1'b0, 2'b00, 3'd0, '0, 1'b0, 2'b00, '0);
    rst_n = 1'b1;
    tick();

    issue(2'b00, 8'd4);
    wait_idle();

    for (int i = 0; i < TERMS; i++) cfg_write(2'b10, 3'(i), 12'(16 * (i + 1)));
    issue(2'b10, 8'd0);
    // Writes while busy must be dropped.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 3'd0, 12'hFFF, 1'b0, 2'b00, '0);
      tick();
    end
    drive(1'b0, 2'b00, 3'd0, '0, 1'b0, 2'b00, '0);
    wait_idle();
    issue(2'b10, 8'd0);
    wait_idle();

    hold_low = 1'b1;
    issue(2'b01, 8'd0);
    for (int i = 0; i < 18; i++) tick();
    hold_low = 1'b0;
    wait_idle();

    // Config write and request in the same cycle.
    drive(1'b1, 2'b11, 3'd0, 12'hABC, 1'b1, 2'b11, '0);
    tick();
    drive(1'b0, 2'b00, 3'd0, '0, 1'b0, 2'b00, '0);
    wait_idle();

    // Reset in the middle of a div issue.
    cfg_write(2'b01, 3'd1, 12'h5A5);
    issue(2'b01, 8'd0);
    tick();
    #2;
    rst_n = 1'b0;
    cq.delete();
    rq.delete();
    clear_model();
    #1;
    check("async_rst_ctl", {bus.pe_op, bus.pe_coeff, bus.pe_first, bus.pe_last,
                            bus.pe_acc_en, bus.opnd_pop}, 32'd0);
    check("async_rst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    issue(2'b01, 8'd0);
    wait_idle();
    issue(2'b00, 8'd0);
    wait_idle();

    for (int c = 0; c < 2500; c++) begin
      tick();
      drive($urandom_range(0, 3) == 0, 2'($urandom), 3'($urandom), 12'($urandom),
            (rq.size() == 0) && ($urandom_range(0, 3) == 0), 2'($urandom),
            8'($urandom_range(0, 6)));
    end
    tick();
    drive(1'b0, 2'b00, 3'd0, '0, 1'b0, 2'b00, '0);
    wait_idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
